// File: rtl/multicore_system_core_rom_loader.sv
// Boot-image loader for a core's dual-port program RAM (drives the RAM's second port).
// Accepts a byte stream: 16-bit little-endian word count L, L*4 payload bytes, 8-bit checksum.
// Payload bytes are packed little-endian into 32-bit words and written from address 0.
// The image is then read back and summed. The attached core is released only after this verify.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   start                 one-cycle pulse; begins a load when not busy
//   in_valid/in_data      byte stream in; in_ready is the registered acceptance flag
//   mem_*                 Avalon slave port of the program RAM (read latency 1)
//   core_reset_req        holds the core in reset until a verified load completes
//   busy, done, error     status; done/error are sticky until the next start
//   words_loaded          words written in the current or last load
module multicore_system_core_rom_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              core_reset_req,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    StIdle, StLen0, StLen1, StData, StCsum, StVerify, StDone, StFail
  } state_e;

  state_e          state;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [ADDR_W:0] word_idx;   // one bit wider than the address so L=2^ADDR_W never wraps
  logic [1:0]      byte_cnt;
  logic [23:0]     word_acc;   // b2,b1,b0 of the word being assembled
  logic [7:0]      sum;
  logic [7:0]      csum;
  logic [7:0]      rb_sum;
  logic            rd_valid;   // mem_readdata holds a verify read this cycle

  logic        accept;
  logic [7:0]  sum_next;
  logic [15:0] len_rx;
  logic [15:0] idx_next;
  logic [15:0] rd_next;
  logic [7:0]  rb_bytes;
  logic [7:0]  rb_sum_next;

  assign accept      = in_valid & in_ready;
  assign sum_next    = sum + in_data;
  assign len_rx      = {in_data, len_lo};
  assign idx_next    = 16'(word_idx) + 16'd1;
  assign rd_next     = 16'(mem_address) + 16'd1;
  assign rb_bytes    = mem_readdata[7:0] + mem_readdata[15:8] +
                       mem_readdata[23:16] + mem_readdata[31:24];
  assign rb_sum_next = rb_sum + rb_bytes;

  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign words_loaded   = word_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      core_reset_req <= 1'b1;
      in_ready       <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 2'b00;
      len_lo         <= '0;
      len            <= '0;
      word_idx       <= '0;
      byte_cnt       <= '0;
      word_acc       <= '0;
      sum            <= '0;
      csum           <= '0;
      rb_sum         <= '0;
      rd_valid       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      case (state)
        StIdle, StDone, StFail: begin
          if (start) begin
            done           <= 1'b0;
            error          <= 2'b00;
            word_idx       <= '0;
            byte_cnt       <= '0;
            sum            <= '0;
            rb_sum         <= '0;
            core_reset_req <= 1'b1;
            busy           <= 1'b1;
            in_ready       <= 1'b1;
            state          <= StLen0;
          end
        end
        StLen0: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= StLen1;
          end
        end
        StLen1: begin
          if (accept) begin
            len <= len_rx;
            if (len_rx == 16'd0 || 32'(len_rx) > MAX_WORDS) begin
              error    <= 2'b01;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              state    <= StFail;
            end else begin
              state <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            sum      <= sum_next;
            byte_cnt <= byte_cnt + 2'd1;
            word_acc <= {in_data, word_acc[23:8]};
            if (byte_cnt == 2'd3) begin
              mem_chipselect <= 1'b1;
              mem_write      <= 1'b1;
              mem_address    <= word_idx[ADDR_W-1:0];
              mem_writedata  <= {in_data, word_acc};
              word_idx       <= idx_next[ADDR_W:0];
              if (idx_next == len) state <= StCsum;
            end
          end
        end
        StCsum: begin
          // The last word's write strobe occupies the first CSUM cycle, so the
          // first verify read can never overtake it.
          if (accept) begin
            csum     <= in_data;
            in_ready <= 1'b0;
            if (in_data != sum) begin
              error <= 2'b10;
              busy  <= 1'b0;
              state <= StFail;
            end else begin
              mem_chipselect <= 1'b1;
              mem_address    <= '0;
              rd_valid       <= 1'b0;
              rb_sum         <= '0;
              state          <= StVerify;
            end
          end
        end
        StVerify: begin
          rd_valid <= mem_chipselect;
          if (mem_chipselect && rd_next < len) begin
            mem_chipselect <= 1'b1;
            mem_address    <= rd_next[ADDR_W-1:0];
          end
          if (rd_valid) rb_sum <= rb_sum_next;
          // Last read's data arrives one cycle after the final address.
          if (rd_valid && !mem_chipselect) begin
            busy <= 1'b0;
            if (rb_sum_next == csum) begin
              done           <= 1'b1;
              core_reset_req <= 1'b0;
              state          <= StDone;
            end else begin
              error <= 2'b11;
              state <= StFail;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_system_core_rom_loader.sv
module tb_multicore_system_core_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [11:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic        core_reset_req;
  logic        busy;
  logic        done;
  logic [1:0]  error;
  logic [12:0] words_loaded;

  always #5 clk = ~clk;

  multicore_system_core_rom_loader #(.ADDR_W(12), .MAX_WORDS(4096)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .core_reset_req (core_reset_req),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .words_loaded   (words_loaded)
  );

  // RAM model, read latency 1; flip corrupts bit 0 of word 0 on readback.
  logic [31:0] ram [0:4095];
  logic        flip = 1'b0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write && (&mem_byteenable)) ram[mem_address] <= mem_writedata;
      else if (!mem_write)
        mem_readdata <= ram[mem_address] ^ ((flip && mem_address == 12'd0) ? 32'h1 : 32'h0);
    end
  end

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  bit bail = 1'b0;
  logic [11:0] last_wr_addr = '0;
  logic [43:0] exp_q[$];   // {addr, data} of each expected write

  typedef struct {
    logic [15:0] len;
    int          delta;
    bit          flp;
    bit          gaps;
    logic [1:0]  err;
    bit          dn;
    int          words;
    int          reads;
  } vec_t;
  vec_t vec[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [43:0] e;
    forever begin
      @(negedge clk);
      if (mem_chipselect && mem_write) begin
        wr_cnt++;
        last_wr_addr = mem_address;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=addr %0h required=no write", mem_address);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_address), 32'(e[43:32]));
          check("write_data", mem_writedata, e[31:0]);
        end
      end else if (mem_chipselect) begin
        rd_cnt++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (bail) return;
    if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      bail     = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 30000) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=1 required=0");
    end
    @(negedge clk);
  endtask

  // Random payload; mid_start raises start during word 100 to confirm it is ignored.
  task automatic run_image(input logic [15:0] len, input int delta, input bit gaps,
                           input bit mid_start);
    logic [7:0] b[4];
    logic [7:0] s;
    s = 8'd0;
    pulse_start();
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    if (len == 16'd0 || len > 16'd4096) return;
    for (int w = 0; w < int'(len); w++) begin
      for (int k = 0; k < 4; k++) begin
        b[k] = 8'($urandom);
        s    = s + b[k];
      end
      exp_q.push_back({12'(w), b[3], b[2], b[1], b[0]});
      for (int k = 0; k < 4; k++) begin
        if (mid_start && w == 100 && k == 0) start = 1'b1;
        send_byte(b[k], gaps);
        start = 1'b0;
      end
    end
    send_byte(s + 8'(delta), gaps);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
    check({tag, "_wr"}, 32'(mem_write), 32'd0);
    check({tag, "_addr"}, 32'(mem_address), 32'd0);
    check({tag, "_wdata"}, mem_writedata, 32'd0);
    check({tag, "_core_rst"}, 32'(core_reset_req), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    int wr0;
    int rd0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    vec[0] = '{16'd0,    0, 1'b0, 1'b0, 2'b01, 1'b0, 0, 0};
    vec[1] = '{16'd4097, 0, 1'b0, 1'b0, 2'b01, 1'b0, 0, 0};
    vec[2] = '{16'd1,    1, 1'b0, 1'b0, 2'b10, 1'b0, 1, 0};
    vec[3] = '{16'd2,    0, 1'b1, 1'b0, 2'b11, 1'b0, 2, 2};
    vec[4] = '{16'd3,    0, 1'b0, 1'b0, 2'b00, 1'b1, 3, 3};
    vec[5] = '{16'd5,    0, 1'b0, 1'b1, 2'b00, 1'b1, 5, 5};
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    // Known-answer image.
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    exp_q.push_back({12'd0, 32'h11223344});
    exp_q.push_back({12'd1, 32'h55667788});
    pulse_start();
    check("kat_busy", 32'(busy), 32'd1);
    foreach (vec[0].len[i]) begin end
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h44, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h11, 1'b0);
    send_byte(8'h88, 1'b0); send_byte(8'h77, 1'b0); send_byte(8'h66, 1'b0); send_byte(8'h55, 1'b0);
    check("kat_core_rst_held", 32'(core_reset_req), 32'd1);
    send_byte(8'h64, 1'b0);
    wait_idle();
    check("kat_done", 32'(done), 32'd1);
    check("kat_error", 32'(error), 32'd0);
    check("kat_words", 32'(words_loaded), 32'd2);
    check("kat_core_rst", 32'(core_reset_req), 32'd0);
    check("kat_writes", 32'(wr_cnt - wr0), 32'd2);
    check("kat_reads", 32'(rd_cnt - rd0), 32'd2);

    // Bytes offered in DONE are not consumed.
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("done_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      wr0  = wr_cnt;
      rd0  = rd_cnt;
      flip = vec[i].flp;
      run_image(vec[i].len, vec[i].delta, vec[i].gaps, 1'b0);
      wait_idle();
      flip = 1'b0;
      check($sformatf("v%0d_error", i), 32'(error), 32'(vec[i].err));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vec[i].dn));
      check($sformatf("v%0d_core_rst", i), 32'(core_reset_req), 32'(!vec[i].dn));
      check($sformatf("v%0d_words", i), 32'(words_loaded), 32'(vec[i].words));
      check($sformatf("v%0d_writes", i), 32'(wr_cnt - wr0), 32'(vec[i].words));
      check($sformatf("v%0d_reads", i), 32'(rd_cnt - rd0), 32'(vec[i].reads));
      check($sformatf("v%0d_queue", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd0);
    end

    // Full-size image with stream gaps and an ignored start pulse.
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    run_image(16'd4096, 0, 1'b1, 1'b1);
    wait_idle();
    check("max_last_addr", 32'(last_wr_addr), 32'hFFF);
    check("max_words", 32'(words_loaded), 32'd4096);
    check("max_done", 32'(done), 32'd1);
    check("max_error", 32'(error), 32'd0);
    check("max_writes", 32'(wr_cnt - wr0), 32'd4096);
    check("max_reads", 32'(rd_cnt - rd0), 32'd4096);

    // Asynchronous reset in the middle of DATA.
    pulse_start();
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back({12'd0, 32'h04030201});
    exp_q.push_back({12'd1, 32'h08070605});
    for (int k = 1; k <= 10; k++) send_byte(8'(k), 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_vals("async");
    exp_q.delete();
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_writes", 32'(wr_cnt - wr0), 32'd0);
    check("post_rst_reads", 32'(rd_cnt - rd0), 32'd0);
    run_image(16'd4, 0, 1'b0, 1'b0);
    wait_idle();
    check("reload_done", 32'(done), 32'd1);
    check("reload_error", 32'(error), 32'd0);
    check("reload_words", 32'(words_loaded), 32'd4);
    check("reload_writes", 32'(wr_cnt - wr0), 32'd4);
    check("reload_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
